// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// -----------------------------------------------------------------------------
// Program counter and next-PC sequencer sitting directly in front of the
// instruction memory. Every cycle it presents a word-aligned fetch address and
// chooses the next PC from these sources, in priority order:
//   jump-register, absolute jump, PC-relative branch, sequential.
// It also handles stall, halt and fault, checks every selected target for
// misalignment and for leaving the instruction-memory window, and counts
// retired fetches.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : synchronous, active-high reset
//   stall          : hold the PC this cycle (halt and redirects are ignored)
//   halt           : enter HALTED at the next edge (the current fetch retires)
//   branch_taken   : take the PC-relative branch
//   branch_imm16   : signed word offset for the branch
//   jump           : take the absolute jump (J/JAL)
//   jump_imm26     : jump word index
//   jr             : take the register jump
//   jr_target      : register jump target byte address
//   pc             : current fetch address to the instruction memory
//   pc_plus4       : pc + 4, used for link and as the branch base
//   fetch_valid    : the instruction at pc is consumed this cycle
//   halted         : block is in the HALTED state
//   fault          : block is in the FAULT state
//   fault_code     : 0 none, 1 misaligned target, 2 out-of-window target
//   fault_target   : offending target address
//   retired_count  : number of fetches consumed since reset
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm16,
  input  logic        jump,
  input  logic [25:0] jump_imm26,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_target,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  localparam logic [1:0] CODE_NONE      = 2'd0;
  localparam logic [1:0] CODE_MISALIGN  = 2'd1;
  localparam logic [1:0] CODE_OUTWINDOW = 2'd2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [31:0] fault_target_q, fault_target_d;

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic [31:0] win_offset;
  logic [1:0]  check_code;
  logic        consume;

  assign pc_plus4 = pc_q + 32'd4;

  // Candidate targets. The branch offset is a signed word count, so it is
  // sign-extended and scaled to bytes before adding to the pc+4 base.
  assign branch_target = pc_plus4 + {{14{branch_imm16[15]}}, branch_imm16, 2'b00};
  assign jump_target   = {pc_plus4[31:28], jump_imm26, 2'b00};

  // Redirect selection; lower-priority redirects asserted together are simply
  // dropped.
  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // Target check on whichever next PC was selected. The window test uses an
  // unsigned offset from the base, so addresses below RESET_PC wrap to a huge
  // offset and are also caught. Misalignment is reported ahead of the window.
  assign win_offset = next_pc - RESET_PC;

  always_comb begin
    check_code = CODE_NONE;
    if (next_pc[1:0] != 2'b00) begin
      check_code = CODE_MISALIGN;
    end else if (win_offset >= 32'(IMEM_BYTES)) begin
      check_code = CODE_OUTWINDOW;
    end
  end

  // A fetch is consumed only while running and not stalled. The reset cycle
  // never consumes anything, whatever state the register currently holds.
  assign consume     = (state_q == ST_RUN) && !stall && !reset;
  assign fetch_valid = consume;

  // Next-state logic. Halt and a faulting target both retire the current
  // instruction but leave the PC where it is; HALTED and FAULT freeze all
  // architectural state until reset.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    retired_d      = retired_q;
    fault_code_d   = fault_code_q;
    fault_target_d = fault_target_q;
    if (consume) begin
      retired_d = retired_q + 32'd1;
      if (halt) begin
        state_d = ST_HALTED;
      end else if (check_code != CODE_NONE) begin
        state_d        = ST_FAULT;
        fault_code_d   = check_code;
        fault_target_d = next_pc;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      retired_q      <= 32'd0;
      fault_code_q   <= CODE_NONE;
      fault_target_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      retired_q      <= retired_d;
      fault_code_q   <= fault_code_d;
      fault_target_q <= fault_target_d;
    end
  end

  assign pc            = pc_q;
  assign halted        = (state_q == ST_HALTED);
  assign fault         = (state_q == ST_FAULT);
  assign fault_code    = fault_code_q;
  assign fault_target  = fault_target_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// -----------------------------------------------------------------------------
// Bench for pc_fetch_unit. A behavioural model tracks the architectural state
// (pc, mode, retired count, fault info) using plain arithmetic on the fetch
// rules; each scenario task drives inputs, advances one clock via cycle(), and
// compares DUT outputs against the model or against fixed expected values.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 4096;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [15:0] branch_imm16;
  logic        jump;
  logic [25:0] jump_imm26;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_target;
  logic [31:0] retired_count;

  int checks   = 0;
  int failures = 0;

  // Model state: mode 0 = running, 1 = halted, 2 = faulted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [1:0]  m_fcode;
  logic [31:0] m_ftgt;

  pc_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_imm16  (branch_imm16),
    .jump          (jump),
    .jump_imm26    (jump_imm26),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .fault         (fault),
    .fault_code    (fault_code),
    .fault_target  (fault_target),
    .retired_count (retired_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    logic [31:0] nxt;
    if (reset) begin
      m_mode = 0; m_pc = RESET_PC; m_ret = 0; m_fcode = 0; m_ftgt = 0;
    end else if (m_mode == 0 && !stall) begin
      m_ret = m_ret + 32'd1;
      if (halt) begin
        m_mode = 1;
      end else begin
        if (jr)                nxt = jr_target;
        else if (jump)         nxt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_imm26) * 32'd4);
        else if (branch_taken) nxt = m_pc + 32'd4 + 32'($signed(branch_imm16)) * 32'd4;
        else                   nxt = m_pc + 32'd4;
        if (nxt % 4 != 0) begin
          m_mode = 2; m_fcode = 2'd1; m_ftgt = nxt;
        end else if (nxt - RESET_PC >= 32'(IMEM_BYTES)) begin
          m_mode = 2; m_fcode = 2'd2; m_ftgt = nxt;
        end else begin
          m_pc = nxt;
        end
      end
    end
  endtask

  // Clock the DUT and model together; returns #1 after the rising edge.
  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; halt = 0; branch_taken = 0; branch_imm16 = 0;
    jump = 0; jump_imm26 = 0; jr = 0; jr_target = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #1;
    checks++;
    if (fetch_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_fetch_valid got=%0b want=0", fetch_valid);
    end
    cycle();
    checks++;
    if (pc !== RESET_PC || pc_plus4 !== RESET_PC + 32'd4 || retired_count !== 32'd0 ||
        halted !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0 || fault_target !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got pc=%h pc4=%h ret=%0d h=%b f=%b fc=%0d ft=%h want pc=%h pc4=%h ret=0 h=0 f=0 fc=0 ft=0",
               pc, pc_plus4, retired_count, halted, fault, fault_code, fault_target, RESET_PC, RESET_PC + 32'd4);
    end
    reset = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    #1;
    checks++;
    if (fetch_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL seq_fetch_valid got=%0b want=1", fetch_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (pc !== exp_pc[i]) begin
        failures++; $display("[TB] FAIL seq_pc[%0d] got=%h want=%h", i, pc, exp_pc[i]);
      end
    end
    checks++;
    if (retired_count !== 32'd4) begin
      failures++; $display("[TB] FAIL seq_retired got=%0d want=4", retired_count);
    end
  endtask

  task automatic test_branch_jump();
    branch_taken = 1; branch_imm16 = 16'hFFFC;
    cycle();
    checks++;
    if (pc !== 32'h04) begin
      failures++; $display("[TB] FAIL branch_back got=%h want=00000004", pc);
    end
    branch_taken = 0; jump = 1; jump_imm26 = 26'h000020;
    cycle();
    checks++;
    if (pc !== 32'h80) begin
      failures++; $display("[TB] FAIL jump_abs got=%h want=00000080", pc);
    end
    jump = 0;
  endtask

  task automatic test_stall_priority();
    stall = 1; jump = 1; jump_imm26 = 26'h000100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fetch_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL stall_fetch_valid[%0d] got=%0b want=0", i, fetch_valid);
      end
      cycle();
      checks++;
      if (pc !== 32'h80 || retired_count !== 32'd6) begin
        failures++; $display("[TB] FAIL stall_hold[%0d] got pc=%h ret=%0d want pc=00000080 ret=6", i, pc, retired_count);
      end
    end
    stall = 0; jump = 0; jr = 1; jr_target = 32'h200; branch_taken = 1; branch_imm16 = 16'h0010;
    cycle();
    checks++;
    if (pc !== 32'h200) begin
      failures++; $display("[TB] FAIL jr_wins got=%h want=00000200", pc);
    end
    clear_inputs();
  endtask

  task automatic test_faults();
    jr = 1; jr_target = 32'h202;
    cycle();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || fault_target !== 32'h202 || pc !== 32'h200 || retired_count !== 32'd8) begin
      failures++;
      $display("[TB] FAIL fault_misalign got f=%b fc=%0d ft=%h pc=%h ret=%0d want f=1 fc=1 ft=00000202 pc=00000200 ret=8",
               fault, fault_code, fault_target, pc, retired_count);
    end
    jr_target = 32'h300;
    cycle();
    checks++;
    if (pc !== 32'h200 || fault_code !== 2'd1 || retired_count !== 32'd8) begin
      failures++; $display("[TB] FAIL fault_sticky got pc=%h fc=%0d ret=%0d want pc=00000200 fc=1 ret=8", pc, fault_code, retired_count);
    end
    do_reset();
    jr = 1; jr_target = 32'h1000;
    cycle();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || fault_target !== 32'h1000 || pc !== 32'h0) begin
      failures++; $display("[TB] FAIL fault_window_jr got f=%b fc=%0d ft=%h pc=%h want f=1 fc=2 ft=00001000 pc=0", fault, fault_code, fault_target, pc);
    end
    do_reset();
    jump = 1; jump_imm26 = 26'h3FF;
    cycle();
    jump = 0;
    checks++;
    if (pc !== 32'hFFC) begin
      failures++; $display("[TB] FAIL jump_last_word got=%h want=00000ffc", pc);
    end
    cycle();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || fault_target !== 32'h1000 || pc !== 32'hFFC) begin
      failures++; $display("[TB] FAIL fault_window_seq got f=%b fc=%0d ft=%h pc=%h want f=1 fc=2 ft=00001000 pc=00000ffc", fault, fault_code, fault_target, pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    cycle();
    cycle();
    halt = 1;
    cycle();
    halt = 0;
    checks++;
    if (halted !== 1'b1 || pc !== 32'h08 || retired_count !== 32'd3) begin
      failures++; $display("[TB] FAIL halt_enter got h=%b pc=%h ret=%0d want h=1 pc=00000008 ret=3", halted, pc, retired_count);
    end
    for (int i = 0; i < 10; i++) begin
      jr = 1'($urandom); jr_target = 32'h40;
      jump = 1'($urandom); jump_imm26 = 26'h10;
      branch_taken = 1; branch_imm16 = 16'h0004;
      #1;
      checks++;
      if (fetch_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL halt_fetch_valid[%0d] got=%0b want=0", i, fetch_valid);
      end
      cycle();
      checks++;
      if (pc !== 32'h08 || retired_count !== 32'd3 || halted !== 1'b1) begin
        failures++; $display("[TB] FAIL halt_frozen[%0d] got pc=%h ret=%0d h=%b want pc=00000008 ret=3 h=1", i, pc, retired_count, halted);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_from_halt();
    reset = 1; jump = 1; jump_imm26 = 26'h55;
    cycle();
    checks++;
    if (pc !== RESET_PC || halted !== 1'b0 || retired_count !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_halted got pc=%h h=%b ret=%0d want pc=%h h=0 ret=0", pc, halted, retired_count, RESET_PC);
    end
    clear_inputs();
    cycle();
    checks++;
    if (pc !== 32'h04) begin
      failures++; $display("[TB] FAIL post_reset_seq got=%h want=00000004", pc);
    end
  endtask

  // Random traffic compared against the model every cycle. Targets are mostly
  // legal but occasionally misaligned or outside the window; an occasional
  // reset pulls the block out of HALTED/FAULT.
  task automatic test_random();
    logic exp_fv;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 99) < 3);
      stall        = ($urandom_range(0, 99) < 15);
      halt         = ($urandom_range(0, 99) < 2);
      jr           = ($urandom_range(0, 99) < 8);
      jump         = ($urandom_range(0, 99) < 8);
      branch_taken = ($urandom_range(0, 99) < 15);
      branch_imm16 = 16'($signed($urandom_range(0, 64)) - 32);
      jump_imm26   = 26'($urandom_range(0, 1100));
      jr_target    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 32'h1100) : ($urandom_range(0, 1023) * 4);
      #1;
      exp_fv = (m_mode == 0) && !stall && !reset;
      checks++;
      if (fetch_valid !== exp_fv) begin
        failures++; $display("[TB] FAIL rand_fetch_valid[%0d] got=%0b want=%0b", i, fetch_valid, exp_fv);
      end
      cycle();
      checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || retired_count !== m_ret || halted !== (m_mode == 1) ||
          fault !== (m_mode == 2) || fault_code !== m_fcode || fault_target !== m_ftgt) begin
        failures++;
        $display("[TB] FAIL rand_state[%0d] got pc=%h pc4=%h ret=%0d h=%b f=%b fc=%0d ft=%h want pc=%h ret=%0d mode=%0d fc=%0d ft=%h",
                 i, pc, pc_plus4, retired_count, halted, fault, fault_code, fault_target, m_pc, m_ret, m_mode, m_fcode, m_ftgt);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    m_mode = 0; m_pc = RESET_PC; m_ret = 0; m_fcode = 0; m_ftgt = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch_jump();
    test_stall_priority();
    test_faults();
    test_halt();
    test_reset_from_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
